// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift sequencer
package shift_seq_pkg;
   localparam int   DATA_W    = 8;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/shift_seq_dp.sv
// rtl/shift_seq_dp.sv - 8-bit bidirectional shift register with parallel load
module shift_seq_dp import shift_seq_pkg::*; (
   input  logic              clk,
   input  logic              clr,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift_en,
   input  logic              dir,
   input  logic              sin,
   output logic [DATA_W-1:0] shift_reg
);

   logic [DATA_W-1:0] shift_reg_q;
   logic [DATA_W-1:0] shift_reg_d;

   always_comb begin
      shift_reg_d = shift_reg_q;
      if (load) begin
         shift_reg_d = load_data;
      end else if (shift_en) begin
         // serial input enters at the end opposite the outgoing bit
         if (dir == DIR_LEFT) begin
            shift_reg_d = {shift_reg_q[DATA_W-2:0], sin};
         end else begin
            shift_reg_d = {sin, shift_reg_q[DATA_W-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         shift_reg_q <= '0;
      end else begin
         shift_reg_q <= shift_reg_d;
      end
   end

   assign shift_reg = shift_reg_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven full-duplex shift sequencer (FSM, bit-rate divider, bit counter)
module shift_seq_ctrl import shift_seq_pkg::*; #(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_dir,
   input  logic [2:0]        cmd_len,
   output logic              sout,
   output logic              sclk,
   input  logic              sin,
   output logic              busy,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        len_q, len_d;
   logic              dir_q, dir_d;
   logic              load;
   logic              shift_en;
   logic [DATA_W-1:0] shift_reg;

   shift_seq_dp u_dp (
      .clk       (clk),
      .clr       (rst),
      .load      (load),
      .load_data (cmd_data),
      .shift_en  (shift_en),
      .dir       (dir_q),
      .sin       (sin),
      .shift_reg (shift_reg)
   );

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      len_d     = len_q;
      dir_d     = dir_q;
      load      = 1'b0;
      shift_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               load      = 1'b1;
               dir_d     = cmd_dir;
               len_d     = (cmd_len == 3'd0) ? 4'd8 : {1'b0, cmd_len};
               bit_cnt_d = 4'd0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               shift_en  = 1'b1;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q + 4'd1 == len_q) begin
                  state_d = DONE;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= 4'd0;
         len_q     <= 4'd0;
         dir_q     <= DIR_LEFT;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         len_q     <= len_d;
         dir_q     <= dir_d;
      end
   end

   // serial pins are only driven while a transfer is in flight
   always_comb begin
      cmd_ready = (state_q == IDLE);
      busy      = (state_q == SHIFT) || (state_q == DONE);
      rsp_valid = (state_q == DONE);
      sout      = 1'b0;
      sclk      = 1'b0;
      if (state_q == SHIFT) begin
         sout = (dir_q == DIR_RIGHT) ? shift_reg[0] : shift_reg[DATA_W-1];
         sclk = (div_cnt_q >= DIV_HALF);
      end
   end

   assign rsp_data = shift_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       cmd_dir;
   logic [2:0] cmd_len;
   logic       sout;
   logic       sclk;
   logic       sin;
   logic       busy;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       dir;
      logic [2:0] len;
      logic [7:0] data;
      logic       loopback;
      logic [7:0] sin_pat;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;

   vec_t tbl[4];

   shift_seq_ctrl #(.CLK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_len   (cmd_len),
      .sout      (sout),
      .sclk      (sclk),
      .sin       (sin),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Result of an exchange: captured bits fill in behind the departing data bits.
   function automatic logic [7:0] model(input logic d, input int n, input logic [7:0] data,
                                        input logic lb, input logic [7:0] pat);
      int r;
      int s;
      r = d ? (int'(data) >> n) : ((int'(data) << n) & 255);
      for (int k = 1; k <= n; k++) begin
         if (lb) s = d ? int'(data[k-1]) : int'(data[8-k]);
         else    s = int'(pat[k-1]);
         if (!d) r = r | (s << (n - k));
         else    r = r | (s << (8 - n + k - 1));
      end
      return r[7:0];
   endfunction

   // Called on a falling edge with the DUT idle; returns on the falling edge where rsp_valid is seen.
   task automatic do_cmd(input logic d, input logic [2:0] l, input logic [7:0] data,
                         input logic lb, input logic [7:0] pat,
                         input logic [7:0] exp_data, input int exp_lat);
      int n;
      int lat;
      int b;
      logic exp_bit;
      n = (l == 3'd0) ? 8 : int'(l);
      chk("cmd_ready_idle", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_len   = l;
      cmd_data  = data;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 80; c++) begin
         if (rsp_valid) begin
            lat = c;
            break;
         end
         b = (c - 1) / 4;
         if (b < n) begin
            exp_bit = d ? data[b] : data[7-b];
            chk("sout", int'(sout), int'(exp_bit));
            chk("sclk", int'(sclk), int'(((c - 1) % 4) >= 2));
            chk("busy_shift", int'(busy), 1);
            chk("cmd_ready_shift", int'(cmd_ready), 0);
            sin = lb ? sout : pat[b];
         end
         @(negedge clk);
      end
      chk("rsp_latency", lat, exp_lat);
      chk("rsp_data", int'(rsp_data), int'(exp_data));
      chk("sout_done", int'(sout), 0);
      chk("sclk_done", int'(sclk), 0);
      sin = 1'b0;
   endtask

   initial begin
      logic       rd;
      logic [2:0] rl;
      logic [7:0] rdata;
      logic       rlb;
      logic [7:0] rpat;
      int         rn;
      int         seen;

      tbl[0] = '{1'b0, 3'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 33};
      tbl[1] = '{1'b1, 3'd0, 8'h01, 1'b0, 8'hFF, 8'hFF, 33};
      tbl[2] = '{1'b0, 3'd3, 8'h0F, 1'b0, 8'hFF, 8'h7F, 13};
      tbl[3] = '{1'b1, 3'd0, 8'h3C, 1'b0, 8'h00, 8'h00, 33};

      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_data = 8'h00;
      cmd_dir = 1'b0;
      cmd_len = 3'd0;
      sin = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_sout", int'(sout), 0);
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);

      for (int i = 0; i < 4; i++) begin
         do_cmd(tbl[i].dir, tbl[i].len, tbl[i].data, tbl[i].loopback, tbl[i].sin_pat,
                tbl[i].exp_data, tbl[i].exp_lat);
         @(negedge clk);
      end

      for (int i = 0; i < 20; i++) begin
         rd    = 1'($urandom_range(0, 1));
         rl    = 3'($urandom_range(0, 7));
         rdata = 8'($urandom);
         rlb   = 1'($urandom_range(0, 1));
         rpat  = 8'($urandom);
         rn    = (rl == 3'd0) ? 8 : int'(rl);
         do_cmd(rd, rl, rdata, rlb, rpat, model(rd, rn, rdata, rlb, rpat), 4 * rn + 1);
         @(negedge clk);
      end

      // response back-pressure with ignored commands during DONE
      rsp_ready = 1'b0;
      do_cmd(1'b0, 3'd2, 8'hC3, 1'b0, 8'h01, 8'h0E, 9);
      for (int i = 0; i < 10; i++) begin
         chk("hold_rsp_valid", int'(rsp_valid), 1);
         chk("hold_rsp_data", int'(rsp_data), 8'h0E);
         chk("hold_cmd_ready", int'(cmd_ready), 0);
         cmd_valid = 1'(i % 2);
         cmd_data  = 8'h55;
         cmd_dir   = 1'b1;
         cmd_len   = 3'd1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_rsp_valid", int'(rsp_valid), 0);
      do_cmd(1'b1, 3'd1, 8'h80, 1'b0, 8'h01, 8'hC0, 5);
      @(negedge clk);

      // reset in the middle of an 8-bit transfer
      chk("pre_rst_ready", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_len   = 3'd0;
      cmd_data  = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      sin = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_sout", int'(sout), 0);
      chk("mrst_sclk", int'(sclk), 0);
      chk("mrst_cmd_ready", int'(cmd_ready), 1);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_rsp_data", int'(rsp_data), 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid || busy) seen++;
         @(negedge clk);
      end
      chk("mrst_no_rsp", seen, 0);
      sin = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command-driven sequencer for an 8-bit bidirectional shift register. It accepts a parallel byte over a valid/ready command port and shifts 1–8 bits out serially, MSB-first or LSB-first, at a programmable bit rate. Serial input bits are captured into the same register as the output bits leave, giving a full-duplex SPI-style exchange. The resulting register contents are returned on a valid/ready response port. It sits between a byte-oriented master and a serial pin pair.

## Interface
- CLK_DIV, default 4: clock cycles per bit period; legal range 2..256.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_data  in  8  byte to load.
- cmd_dir  in  1  0 = left shift / MSB-first; 1 = right shift / LSB-first.
- cmd_len  in  3  bits to shift; 0 means 8.
- sout  out  1  serial data out.
- sclk  out  1  bit clock.
- sin  in  1  serial data in.
- busy  out  1  high in SHIFT and DONE.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when high together with rsp_valid.
- rsp_data  out  8  register contents after the last shift.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - SHIFT.
  - DONE: rsp_valid=1.
- Reset values:
  - State IDLE; register and counters 0.
  - sout=0, sclk=0, busy=0, rsp_valid=0, rsp_data=0, cmd_ready=1.
- Command accept, IDLE→SHIFT:
  - Register ← cmd_data.
  - dir and len latched; cmd_len=0 latched as 8.
  - bit_cnt=0, div_cnt=0.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - Shift event on the cycle where div_cnt==CLK_DIV-1.
  - dir=0: reg ← {reg[6:0], sin}.
  - dir=1: reg ← {sin, reg[7:1]}.
  - Each shift increments bit_cnt.
  - When the len-th shift occurs, go to DONE.
- sout:
  - reg[7] when dir=0, reg[0] when dir=1, in SHIFT.
  - 0 in IDLE and DONE.
- sclk:
  - 1 when div_cnt ≥ CLK_DIV/2 (integer divide), in SHIFT.
  - 0 otherwise.
- sin is sampled only on shift-event cycles.
- DONE:
  - rsp_data = register; held stable while rsp_ready=0.
  - Handshake returns to IDLE on the next cycle.
- cmd_valid outside IDLE is ignored. No queuing; DONE→IDLE costs one cycle before the next accept.
- Reset asserted in any state:
  - Next cycle is IDLE with reset values.
  - In-flight command is dropped; no rsp_valid is produced for it.
- Unshifted bits remain in the register. A partial-length result keeps the residue of cmd_data in the untouched bit positions.

## Timing
- Accept at edge T → SHIFT from T+1. The first bit is on sout at T+1.
- Shift k (1-based) occurs at edge T+k·CLK_DIV.
- rsp_valid rises at T+1+len·CLK_DIV.
- Each sout bit is stable for exactly CLK_DIV cycles.
- sclk is low in the first half of each bit period and high in the second half.
- Minimum command-to-command spacing: len·CLK_DIV + 2 cycles, with rsp_ready held high.

## Structure
- Package shift_seq_pkg holds:
  - State enum (IDLE, SHIFT, DONE).
  - DATA_W=8 constant.
  - Direction constants DIR_LEFT=0 and DIR_RIGHT=1.
- One sub-module, shift_seq_dp: 8-bit register with load, shift_en, dir and sin inputs.
  - Synchronous active-high clear.
  - Exports reg, from which the parent derives sout.
- FSM, div_cnt and bit_cnt live in the top module.

## Test plan
All scenarios use CLK_DIV=4.
- dir=0, len=8, data=0xA5, sin looped to sout → sout 1,0,1,0,0,1,0,1; rsp_data=0xA5; rsp_valid 33 cycles after accept.
- dir=1, len=8, data=0x01, sin=1 → sout 1 then seven 0s; rsp_data=0xFF.
- dir=0, len=3, data=0x0F, sin=1 → sout 0,0,0; rsp_data=0x7F; rsp_valid 13 cycles after accept.
- rsp_ready low for 10 cycles in DONE, cmd_valid pulsed during that time → rsp_valid and rsp_data held, cmd_ready=0, command ignored; accept succeeds 1 cycle after the response handshake.
- rst pulsed after the 2nd shift of an 8-bit command → next cycle IDLE, sout=0, sclk=0, cmd_ready=1, no rsp_valid ever.
- cmd_len=0, data=0x3C, dir=1, sin=0 → 8 shifts, rsp_data=0x00, rsp_valid 33 cycles after accept.
